// File: rtl/button_event_gen_pkg.sv
// Shared definitions for button_event_gen and anything that decodes its state.
// State encoding is fixed so downstream FSMs and benches agree on held/state.
`timescale 1ns/1ps
package button_event_gen_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_PRESSED = ST_PRESSED,
    S_LONG    = ST_LONG
  } state_e;

endpackage

// File: rtl/button_event_gen_hold_timer.sv
// Hold timer: CNT_W-bit up-counter with synchronous clear and enable.
// tc is high while the count equals the selected limit
// (LONG_CYCLES-1 when sel_repeat=0, REPEAT_CYCLES-1 when sel_repeat=1).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          clear count to 0 (wins over en)
//   en           increment count
//   sel_repeat   limit select
//   tc           terminal-count compare
`timescale 1ns/1ps
module button_event_gen_hold_timer #(
  parameter int CNT_W         = 8,
  parameter int LONG_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel_repeat,
  output logic tc
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == (sel_repeat ? REP_LIM : LONG_LIM));

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle key events
// (press, release, long-press, auto-repeat) plus a held level.
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one cycle on a new press
//   release_pulse  one cycle on release
//   long_press     one cycle when hold reaches LONG_CYCLES
//   repeat_pulse   one cycle every REPEAT_CYCLES after long_press
//   held           1 while not idle
`timescale 1ns/1ps
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      LONG_CYCLES > (2 ** CNT_W) || REPEAT_CYCLES > (2 ** CNT_W)) begin : g_bad_params
    $error("button_event_gen: LONG_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end

  state_e state_q, state_d;
  logic   btn_q;
  logic   press_q, press_d;
  logic   release_q, release_d;
  logic   long_q, long_d;
  logic   repeat_q, repeat_d;
  logic   held_q, held_d;
  logic   rise;
  logic   tmr_clr, tmr_en, tmr_tc;

  // btn_q resets to 1 so a button held through reset is not seen as a new press.
  assign rise = btn_level & ~btn_q;

  button_event_gen_hold_timer #(
    .CNT_W        (CNT_W),
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .sel_repeat(state_q == S_LONG),
    .tc        (tmr_tc)
  );

  // Release is tested first so it wins over a coincident long/repeat threshold.
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!btn_level) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          tmr_clr   = 1'b1;
        end else if (tmr_tc) begin
          state_d = S_LONG;
          long_d  = 1'b1;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_LONG: begin
        if (!btn_level) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          tmr_clr   = 1'b1;
        end else if (tmr_tc) begin
          repeat_d = 1'b1;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
    held_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_level;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
